im_fetch_unit: RTL and testbench

//  Parametrised instruction memory with a registered, handshaked fetch port for the pipelined CPU.

---
 rtl/im_fetch_unit.sv | 116 +++++++++++
 tb/tb_im_fetch_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/im_fetch_unit.sv
// Instruction memory with a registered, handshaked fetch port, fault reporting,
// a byte-enable program loader active in BOOT, and an accepted-fetch counter.
module im_fetch_unit #(
  parameter int          ADDR_W        = 10,
  parameter int          DEPTH         = 256,
  parameter string       INIT_FILE     = "",
  parameter logic [31:0] NOP_INSN      = 32'h0,
  parameter bit          BOOT_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  input  logic              flush,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_ins,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic [1:0]        rsp_fault,
  input  logic              ld_en,
  input  logic [ADDR_W-3:0] ld_addr,
  input  logic [31:0]       ld_data,
  input  logic [3:0]        ld_be,
  input  logic              boot_done,
  output logic              ld_err,
  output logic [31:0]       fetch_cnt
);

  localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-2:0] LP_DEPTH = (ADDR_W-1)'(DEPTH);
  localparam logic [0:0]        ST_BOOT  = 1'b0;
  localparam logic [0:0]        ST_RUN   = 1'b1;
  localparam logic [0:0]        ST_RESET = BOOT_ON_RESET ? ST_BOOT : ST_RUN;

  logic [31:0]       r_mem [DEPTH];
  logic [0:0]        r_state;
  logic              r_rsp_valid;
  logic [31:0]       r_rsp_ins;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [1:0]        r_rsp_fault;
  logic              r_ld_err;
  logic [31:0]       r_fetch_cnt;

  logic              w_req_ready;
  logic              w_accept;
  logic              w_misalign;
  logic              w_out_of_range;
  logic [1:0]        w_fault;
  logic              w_ld_in_range;
  logic              w_wr_en;
  logic [IDX_W-1:0]  w_rd_idx;
  logic [IDX_W-1:0]  w_ld_idx;

  assign w_req_ready    = (r_state == ST_RUN) & ~flush & (~r_rsp_valid | rsp_ready);
  assign w_accept       = req_valid & w_req_ready;
  assign w_misalign     = (req_pc[1:0] != 2'b00);
  assign w_out_of_range = ({1'b0, req_pc[ADDR_W-1:2]} >= LP_DEPTH);
  assign w_rd_idx       = req_pc[IDX_W+1:2];

  always_comb begin
    w_fault = 2'b00;
    if (w_misalign)          w_fault = 2'b01;
    else if (w_out_of_range) w_fault = 2'b10;
  end

  assign w_ld_in_range = ({1'b0, ld_addr} < LP_DEPTH);
  assign w_ld_idx      = ld_addr[IDX_W-1:0];
  assign w_wr_en       = rstn & ld_en & (r_state == ST_BOOT) & w_ld_in_range;

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (ld_be[i]) r_mem[w_ld_idx][8*i +: 8] <= ld_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ST_RESET;
      r_ld_err <= 1'b0;
    end else begin
      r_ld_err <= ld_en & ((r_state == ST_RUN) | ~w_ld_in_range);
      if (r_state == ST_BOOT && boot_done) r_state <= ST_RUN;
    end
  end

  // Stall holds everything; drain and flush only clear valid, payload keeps its last value.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_ins   <= NOP_INSN;
      r_rsp_pc    <= '0;
      r_rsp_fault <= 2'b00;
      r_fetch_cnt <= 32'd0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_pc    <= req_pc;
      r_rsp_fault <= w_fault;
      r_rsp_ins   <= (w_fault == 2'b00) ? r_mem[w_rd_idx] : NOP_INSN;
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
    end else if (flush || rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_ins   = r_rsp_ins;
  assign rsp_pc    = r_rsp_pc;
  assign rsp_fault = r_rsp_fault;
  assign ld_err    = r_ld_err;
  assign fetch_cnt = r_fetch_cnt;

endmodule

// File: tb/tb_im_fetch_unit.sv
// Bench for im_fetch_unit: spec-level cycle model plus response scoreboard,
// a table of fetch vectors and hand sequences for boot, stall, flush and reset.
module tb_im_fetch_unit;

  localparam int          ADDR_W = 10;
  localparam int          DEPTH  = 128;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rstn;
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_pc;
  logic              flush;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_ins;
  logic [ADDR_W-1:0] rsp_pc;
  logic [1:0]        rsp_fault;
  logic              ld_en;
  logic [ADDR_W-3:0] ld_addr;
  logic [31:0]       ld_data;
  logic [3:0]        ld_be;
  logic              boot_done;
  logic              ld_err;
  logic [31:0]       fetch_cnt;

  im_fetch_unit #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .INIT_FILE(""), .NOP_INSN(NOP), .BOOT_ON_RESET(1'b1)
  ) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready), .req_pc(req_pc),
    .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ins(rsp_ins),
    .rsp_pc(rsp_pc), .rsp_fault(rsp_fault), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_be(ld_be), .boot_done(boot_done), .ld_err(ld_err),
    .fetch_cnt(fetch_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ins;
    logic [1:0]        fault;
  } rsp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [1:0]        fault;
    logic [31:0]       ins;
  } vec_t;

  rsp_t        sb[$];
  logic [31:0] model_mem [DEPTH];
  logic        m_run;
  logic        m_valid;
  logic [31:0] m_cnt;
  logic        m_ld_err;
  logic        m_rst_seen;
  logic [31:0] drv_ins;
  logic [1:0]  drv_fault;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result of a fetch, derived from the loaded image.
  task automatic fetch_set(input logic [ADDR_W-1:0] pc);
    req_pc = pc;
    if (pc[1:0] != 2'b00) begin
      drv_fault = 2'b01; drv_ins = NOP;
    end else if (int'(pc >> 2) >= DEPTH) begin
      drv_fault = 2'b10; drv_ins = NOP;
    end else begin
      drv_fault = 2'b00; drv_ins = model_mem[pc[ADDR_W-1:2]];
    end
  endtask

  task automatic load(input int addr, input logic [31:0] data, input logic [3:0] be);
    ld_en = 1'b1; ld_addr = (ADDR_W-2)'(addr); ld_data = data; ld_be = be;
    tick();
    ld_en = 1'b0;
  endtask

  // Cycle model: check the present outputs, then advance to the next edge.
  always @(negedge clk) begin
    logic exp_rr;
    rsp_t head;
    if (!rstn) begin
      m_run = 1'b0; m_valid = 1'b0; m_cnt = 0; m_ld_err = 1'b0; m_rst_seen = 1'b1;
      sb.delete();
    end else begin
      exp_rr = m_run & ~flush & (~m_valid | rsp_ready);
      chk("req_ready", {31'd0, req_ready}, {31'd0, exp_rr});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      chk("fetch_cnt", fetch_cnt, m_cnt);
      chk("ld_err", {31'd0, ld_err}, {31'd0, m_ld_err});
      if (m_rst_seen) begin
        chk("rst_ins", rsp_ins, NOP);
        chk("rst_pc", {22'd0, rsp_pc}, 32'd0);
        chk("rst_fault", {30'd0, rsp_fault}, 32'd0);
        m_rst_seen = 1'b0;
      end
      if (m_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          head = sb[0];
          chk("rsp_pc", {22'd0, rsp_pc}, {22'd0, head.pc});
          chk("rsp_ins", rsp_ins, head.ins);
          chk("rsp_fault", {30'd0, rsp_fault}, {30'd0, head.fault});
          if (flush) begin
            void'(sb.pop_front());
            $display("rsp pc=%h flushed", head.pc);
          end else if (rsp_ready) begin
            void'(sb.pop_front());
            $display("rsp pc=%h ins=%h fault=%b taken", rsp_pc, rsp_ins, rsp_fault);
          end
        end
      end
      if (req_valid && exp_rr) begin
        sb.push_back('{pc: req_pc, ins: drv_ins, fault: drv_fault});
        m_valid = 1'b1;
        m_cnt = m_cnt + 1;
      end else if (flush || rsp_ready) begin
        m_valid = 1'b0;
      end
      m_ld_err = ld_en & (m_run | (int'(ld_addr) >= DEPTH));
      if (ld_en && !m_run && int'(ld_addr) < DEPTH) begin
        for (int i = 0; i < 4; i++)
          if (ld_be[i]) model_mem[ld_addr][8*i +: 8] = ld_data[8*i +: 8];
      end
      if (!m_run && boot_done) m_run = 1'b1;
    end
  end

  vec_t vecs [9];

  initial begin
    vecs[0] = '{pc: 10'h014, fault: 2'b00, ins: 32'hDEADAAEF};
    vecs[1] = '{pc: 10'h000, fault: 2'b00, ins: 32'h8C010004};
    vecs[2] = '{pc: 10'h002, fault: 2'b01, ins: NOP};
    vecs[3] = '{pc: 10'h3FC, fault: 2'b10, ins: NOP};
    vecs[4] = '{pc: 10'h3FE, fault: 2'b01, ins: NOP};
    vecs[5] = '{pc: 10'h200, fault: 2'b10, ins: NOP};
    vecs[6] = '{pc: 10'h018, fault: 2'b00, ins: 32'h1000_0006};
    vecs[7] = '{pc: 10'h01C, fault: 2'b00, ins: 32'hCAFE_F00D};
    vecs[8] = '{pc: 10'h001, fault: 2'b01, ins: NOP};

    rstn = 1'b0; req_valid = 1'b0; req_pc = '0; flush = 1'b0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_be = '0; boot_done = 1'b0;
    drv_ins = NOP; drv_fault = 2'b00;
    repeat (2) tick();
    rstn = 1'b1;
    tick();

    // BOOT: requests must be refused
    fetch_set(10'h000); req_valid = 1'b1;
    repeat (2) tick();
    req_valid = 1'b0;

    load(0, 32'h8C010004, 4'hF);
    for (int i = 1; i < 8; i++) load(i, 32'h1000_0000 | i, 4'hF);
    load(5, 32'hDEADBEEF, 4'hF);
    load(5, 32'h0000AA00, 4'b0010);
    load(6, 32'hFFFF_FFFF, 4'b0000);
    load(100, 32'h5555_5555, 4'hF);
    load(DEPTH + 5, 32'h1234_5678, 4'hF);
    boot_done = 1'b1;
    load(7, 32'hCAFE_F00D, 4'hF);
    boot_done = 1'b0;
    tick();
    boot_done = 1'b1; tick(); boot_done = 1'b0;

    // back-to-back 0,4,8
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_set(ADDR_W'(4 * i)); req_valid = 1'b1; tick();
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("cnt_b2b", fetch_cnt, 32'd3);
    tick();

    // table vectors, streamed back-to-back
    for (int i = 0; i < 9; i++) begin
      req_pc = vecs[i].pc; drv_ins = vecs[i].ins; drv_fault = vecs[i].fault;
      req_valid = 1'b1;
      tick();
    end
    req_valid = 1'b0;
    tick();

    // stall for 3 cycles with a request waiting
    rsp_ready = 1'b0;
    fetch_set(10'h004); req_valid = 1'b1; tick();
    fetch_set(10'h008);
    repeat (3) tick();
    rsp_ready = 1'b1; tick();
    req_valid = 1'b0;
    repeat (2) tick();

    // load in RUN: error pulse, memory untouched
    load(5, 32'h0000_0000, 4'hF);
    tick();
    fetch_set(10'h014); req_valid = 1'b1; tick(); req_valid = 1'b0;
    tick();

    // flush with a valid response and a competing request
    rsp_ready = 1'b0;
    fetch_set(10'h000); req_valid = 1'b1; tick();
    flush = 1'b1; rsp_ready = 1'b1; fetch_set(10'h004); tick();
    flush = 1'b0; req_valid = 1'b0; tick();
    tick();

    // reset with a response pending; memory survives
    rsp_ready = 1'b0;
    fetch_set(10'h008); req_valid = 1'b1; tick();
    req_valid = 1'b0;
    rstn = 1'b0; tick();
    rstn = 1'b1; rsp_ready = 1'b1; tick();
    boot_done = 1'b1; tick(); boot_done = 1'b0;
    fetch_set(10'h014); req_valid = 1'b1; tick(); req_valid = 1'b0;
    repeat (3) tick();

    @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
